// File: rtl/align_operands.sv
// Alignment stage ahead of the FP adder: unpacks two IEEE754 singles, orders them by
// magnitude and right-shifts the smaller fraction by the exponent gap, keeping a sticky bit.
module align_operands #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] aIn,
    input  logic [31:0] bIn,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] fracLargeOut,
    output logic [31:0] fracSmallOut,
    output logic [7:0]  exponentOut,
    output logic        signLargeOut,
    output logic        signSmallOut,
    output logic        opOut,
    output logic        stickyOut,
    output logic        swappedOut,
    output logic        specialOut
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t      state;
    logic [4:0]  remaining;

    logic [7:0]  exp_a, exp_b, exp_large, exp_small, exp_diff;
    logic [31:0] frac_a, frac_b;
    logic        a_larger, special;
    logic [4:0]  shift_n;
    logic [4:0]  step;
    logic [31:0] shift_mask;

    // Any gap of 25 or more already pushes every fraction bit into sticky.
    function automatic logic [4:0] sat_shift_count(input logic [7:0] diff);
        return (diff > 8'd25) ? 5'd25 : diff[4:0];
    endfunction

    always_comb begin
        exp_a     = (aIn[30:23] == 8'h00) ? 8'd1 : aIn[30:23];
        exp_b     = (bIn[30:23] == 8'h00) ? 8'd1 : bIn[30:23];
        frac_a    = {8'h00, |aIn[30:23], aIn[22:0]};
        frac_b    = {8'h00, |bIn[30:23], bIn[22:0]};
        a_larger  = (exp_a > exp_b) || ((exp_a == exp_b) && (frac_a >= frac_b));
        special   = (&aIn[30:23]) | (&bIn[30:23]);
        exp_large = a_larger ? exp_a : exp_b;
        exp_small = a_larger ? exp_b : exp_a;
        exp_diff  = exp_large - exp_small;
        shift_n   = special ? 5'd0 : sat_shift_count(exp_diff);
    end

    // Last SHIFT cycle may move fewer than SHIFT_STEP bits.
    always_comb begin
        step       = (remaining < STEP) ? remaining : STEP;
        shift_mask = (32'd1 << step) - 32'd1;
    end

    assign inReady = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            remaining    <= 5'd0;
            outValid     <= 1'b0;
            fracLargeOut <= 32'd0;
            fracSmallOut <= 32'd0;
            exponentOut  <= 8'd0;
            signLargeOut <= 1'b0;
            signSmallOut <= 1'b0;
            opOut        <= 1'b0;
            stickyOut    <= 1'b0;
            swappedOut   <= 1'b0;
            specialOut   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        fracLargeOut <= a_larger ? frac_a : frac_b;
                        fracSmallOut <= a_larger ? frac_b : frac_a;
                        exponentOut  <= exp_large;
                        signLargeOut <= a_larger ? aIn[31] : bIn[31];
                        signSmallOut <= a_larger ? bIn[31] : aIn[31];
                        opOut        <= aIn[31] ^ bIn[31];
                        stickyOut    <= 1'b0;
                        swappedOut   <= ~a_larger;
                        specialOut   <= special;
                        remaining    <= shift_n;
                        if (shift_n == 5'd0) begin
                            state    <= DONE;
                            outValid <= 1'b1;
                        end else begin
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    fracSmallOut <= fracSmallOut >> step;
                    stickyOut    <= stickyOut | (|(fracSmallOut & shift_mask));
                    remaining    <= remaining - step;
                    if (remaining == step) begin
                        state    <= DONE;
                        outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        state    <= IDLE;
                        outValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_align_operands.sv
// Bench for align_operands: three instances (SHIFT_STEP 1, 2, 8) share the input
// handshake and are compared every valid cycle against an arithmetic reference model.
module tb_align_operands;

    localparam int NDUT = 3;
    localparam int STEPS[NDUT] = '{1, 2, 8};

    typedef struct {
        logic [31:0] fl, fs;
        logic [7:0]  ex;
        logic        sl, ss, op, st, sw, sp;
        int          n;
    } exp_t;

    logic        clk, rst_n, inValid, outReady;
    logic [31:0] aIn, bIn;
    logic        ir[NDUT], ov[NDUT];
    logic [31:0] fl[NDUT], fs[NDUT];
    logic [7:0]  ex[NDUT];
    logic        sl[NDUT], ss[NDUT], op[NDUT], st[NDUT], sw[NDUT], sp[NDUT];

    int   tests = 0, fails = 0, cyc = 0, acc = 0;
    exp_t expd;
    logic pend;
    logic seen[NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        align_operands #(.SHIFT_STEP(STEPS[g])) u_dut (
            .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(ir[g]),
            .aIn(aIn), .bIn(bIn), .outValid(ov[g]), .outReady(outReady),
            .fracLargeOut(fl[g]), .fracSmallOut(fs[g]), .exponentOut(ex[g]),
            .signLargeOut(sl[g]), .signSmallOut(ss[g]), .opOut(op[g]),
            .stickyOut(st[g]), .swappedOut(sw[g]), .specialOut(sp[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int ea, eb, fa, fb, el, es, fsm, d;
        logic a_big;
        ea = (a[30:23] == 8'h00) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 8'h00) ? 1 : int'(b[30:23]);
        fa = int'({a[30:23] != 8'h00, a[22:0]});
        fb = int'({b[30:23] != 8'h00, b[22:0]});
        a_big = (ea > eb) || (ea == eb && fa >= fb);
        el  = a_big ? ea : eb;
        es  = a_big ? eb : ea;
        fsm = a_big ? fb : fa;
        r.sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        d = el - es;
        r.n  = r.sp ? 0 : (d > 25 ? 25 : d);
        r.fl = 32'(a_big ? fa : fb);
        r.fs = 32'(fsm >> r.n);
        r.st = (fsm % (1 << r.n)) != 0;
        r.ex = 8'(el);
        r.sl = a_big ? a[31] : b[31];
        r.ss = a_big ? b[31] : a[31];
        r.op = a[31] ^ b[31];
        r.sw = !a_big;
        return r;
    endfunction

    function automatic logic [79:0] pack_dut(input int i);
        return {2'b00, fl[i], fs[i], ex[i], sl[i], ss[i], op[i], st[i], sw[i], sp[i]};
    endfunction

    function automatic logic [79:0] pack_exp(input exp_t e);
        return {2'b00, e.fl, e.fs, e.ex, e.sl, e.ss, e.op, e.st, e.sw, e.sp};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model while any result is presented.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (ov[i] === 1'b1) begin
                chk($sformatf("pending[%0d]", i), 80'(pend), 80'd1);
                chk($sformatf("data[%0d]", i), pack_dut(i), pack_exp(expd));
                chk($sformatf("inReady_busy[%0d]", i), 80'(ir[i]), 80'd0);
                if (!seen[i]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("latency[%0d]", i), 80'(cyc - acc),
                        80'(1 + (expd.n + STEPS[i] - 1) / STEPS[i]));
                end
            end
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        aIn = a; bIn = b; inValid = 1'b1;
        expd = model(a, b);
        acc  = cyc;
        pend = 1'b1;
        for (int i = 0; i < NDUT; i++) seen[i] = 1'b0;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        logic all;
        k = 0;
        all = 1'b0;
        while (!all && k < 40) begin
            all = 1'b1;
            for (int i = 0; i < NDUT; i++) if (ov[i] !== 1'b1) all = 1'b0;
            if (!all) begin
                @(negedge clk);
                k++;
            end
        end
        chk("done_timeout", 80'(all), 80'd1);
    endtask

    task automatic release_out();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        pend = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("idle_ready[%0d]", i), 80'(ir[i]), 80'd1);
            chk($sformatf("idle_valid[%0d]", i), 80'(ov[i]), 80'd0);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("%s_ready[%0d]", tag, i), 80'(ir[i]), 80'd1);
            chk($sformatf("%s_valid[%0d]", tag, i), 80'(ov[i]), 80'd0);
            chk($sformatf("%s_regs[%0d]", tag, i), pack_dut(i), 80'd0);
        end
    endtask

    initial begin
        rst_n = 1'b1; inValid = 1'b0; outReady = 1'b0;
        aIn = 32'd0; bIn = 32'd0; pend = 1'b0;
        for (int i = 0; i < NDUT; i++) seen[i] = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk_reset("reset");
        @(negedge clk) rst_n = 1'b1;

        // equal operands, no shift
        start(32'h3F800000, 32'h3F800000);
        wait_done();
        chk("t1_fl", 80'(fl[0]), 80'h00800000);
        chk("t1_fs", 80'(fs[0]), 80'h00800000);
        chk("t1_ex", 80'(ex[0]), 80'h7F);
        chk("t1_flags", 80'({op[0], st[0], sw[0]}), 80'b000);
        release_out();

        // B larger, gap 3
        start(32'h3F800000, 32'h41000000);
        wait_done();
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("t2_sw[%0d]", i), 80'(sw[i]), 80'd1);
            chk($sformatf("t2_ex[%0d]", i), 80'(ex[i]), 80'h82);
            chk($sformatf("t2_fl[%0d]", i), 80'(fl[i]), 80'h00800000);
            chk($sformatf("t2_fs[%0d]", i), 80'(fs[i]), 80'h00100000);
            chk($sformatf("t2_st[%0d]", i), 80'(st[i]), 80'd0);
        end
        release_out();

        // differing signs, gap 1
        start(32'h3FC00000, 32'hBF400000);
        wait_done();
        chk("t3_signs", 80'({op[0], sl[0], ss[0]}), 80'b101);
        chk("t3_fl", 80'(fl[0]), 80'h00C00000);
        chk("t3_fs", 80'(fs[0]), 80'h00600000);
        release_out();

        // gap 30 saturates to 25
        start(32'h3F800000, 32'h30800001);
        wait_done();
        chk("t4_fs1", 80'(fs[0]), 80'd0);
        chk("t4_st1", 80'(st[0]), 80'd1);
        chk("t4_fs8", 80'(fs[2]), 80'd0);
        chk("t4_st8", 80'(st[2]), 80'd1);
        release_out();

        // sticky from a single shifted-out bit, and a denormal pair
        start(32'h3F800000, 32'h3F000001);
        wait_done();
        chk("t7_fs", 80'(fs[1]), 80'h00400000);
        chk("t7_st", 80'(st[1]), 80'd1);
        release_out();
        start(32'h00000003, 32'h00400000);
        wait_done();
        chk("t8_sw", 80'(sw[0]), 80'd1);
        release_out();

        // backpressure: hold 10 cycles, stray inValid must be ignored
        start(32'h3F800000, 32'h41000000);
        wait_done();
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                aIn = 32'h40400000; bIn = 32'hC0000000; inValid = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            @(negedge clk);
        end
        inValid = 1'b0;
        chk("t5_fs_held", 80'(fs[0]), 80'h00100000);
        release_out();

        // reset during SHIFT, then a special operand
        start(32'h3F800000, 32'h30800001);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        pend = 1'b0;
        #1 chk_reset("midreset");
        @(negedge clk) rst_n = 1'b1;
        start(32'h7F800000, 32'h3F800000);
        wait_done();
        chk("t6_sp", 80'(sp[0]), 80'd1);
        chk("t6_fs", 80'(fs[0]), 80'h00800000);
        chk("t6_ex", 80'(ex[2]), 80'hFF);
        release_out();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/align_operands.md
Name: align_operands

Overview:
- Pre-adder alignment stage of the single-precision FP adder; the inverse of the post-ALU normalise step.
- Accepts two IEEE754 operands over a valid/ready handshake and unpacks them (hidden bit restored).
- Orders them by magnitude, then right-shifts the smaller fraction by the exponent difference, SHIFT_STEP bits per cycle, tracking a sticky bit.
- Presents aligned fractions and the common exponent to the big ALU.

Parameters:
SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
inValid  input  1  operands valid
inReady  output  1  block can accept operands
aIn  input  32  operand A, IEEE754 single
bIn  input  32  operand B, IEEE754 single
outValid  output  1  aligned result valid
outReady  input  1  downstream accepts result
fracLargeOut  output  32  larger-magnitude fraction; hidden bit at [23]; [31:24]=0
fracSmallOut  output  32  smaller fraction after right shift, same format
exponentOut  output  8  exponent of larger operand
signLargeOut  output  1  sign of larger operand
signSmallOut  output  1  sign of smaller operand
opOut  output  1  0 = effective add, 1 = effective subtract (signs differ)
stickyOut  output  1  OR of all bits shifted out of the small fraction
swappedOut  output  1  1 when B was the larger operand
specialOut  output  1  either exponent == 8'hFF (Inf/NaN)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; all output registers 0; outValid 0.
  - inReady 1, since it decodes combinationally from IDLE.
- States: IDLE, SHIFT, DONE.
- inReady = (state == IDLE). inValid is ignored in SHIFT and DONE.
- Unpack, performed on the accept edge (IDLE, inValid = 1):
  - frac = {8'h00, hidden, f[22:0]}; hidden = (exp != 0).
  - Effective exponent for denormals (exp == 0) is 1.
- Ordering:
  - A is larger if expA > expB, or if expA == expB and fracA >= fracB.
  - Otherwise B is larger and swappedOut = 1.
  - A larger-or-equal tie does not swap.
- Shift count n = min(expLarge - expSmall, 25).
- When specialOut = 1: n is forced to 0; fractions and exponent pass through unshifted.
- Accept-edge transitions:
  - n == 0 -> DONE.
  - n > 0 -> SHIFT, with remaining = n and sticky = 0.
- SHIFT, each edge:
  - s = min(SHIFT_STEP, remaining).
  - sticky |= OR of the low s bits of the small fraction.
  - Small fraction >>= s; remaining -= s.
  - When remaining reaches 0 on this edge, the state becomes DONE on the same edge.
- DONE:
  - outValid = 1.
  - All outputs are held stable until outValid & outReady on an edge, then return to IDLE.
  - No new operand is accepted on that edge.
- Latency: outValid rises 1 + ceil(n / SHIFT_STEP) edges after the accept edge (accept edge counts as 1).
- Throughput: one operation per latency + 1 cycles minimum.
- Saturation: a difference >= 25 shifts the small fraction fully to 0. Every 1 bit in it lands in sticky.
- Reset mid-operation (SHIFT or DONE) aborts: the in-flight result is discarded and outValid drops immediately.
- Zero operands: exp 0, frac 0 is treated as a denormal 0 and aligns normally.
- Output registers update only on the accept edge and on SHIFT edges.

Test Plan:
1. aIn=0x3F800000, bIn=0x3F800000, SHIFT_STEP=1 -> outValid 1 edge after accept; fracLarge=fracSmall=0x00800000, exponentOut=0x7F, opOut=0, stickyOut=0, swappedOut=0.
2. aIn=0x3F800000, bIn=0x41000000, SHIFT_STEP=1 -> swappedOut=1, exponentOut=0x82, fracLarge=0x00800000, fracSmall=0x00100000, stickyOut=0, outValid 4 edges after accept; repeat with SHIFT_STEP=2 -> 3 edges, same data.
3. aIn=0x3FC00000, bIn=0xBF400000 -> opOut=1, signLargeOut=0, signSmallOut=1, exponentOut=0x7F, fracLarge=0x00C00000, fracSmall=0x00600000, stickyOut=0, latency 2.
4. aIn=0x3F800000, bIn=0x30800001 (diff 30, saturated to 25) -> fracSmall=0, stickyOut=1, latency 26 edges at SHIFT_STEP=1, 5 edges at SHIFT_STEP=8.
5. Case 2 with outReady held low 10 cycles -> outValid and all outputs constant, inReady 0, a pulsed inValid with new operands ignored; outReady high 1 cycle -> IDLE, inReady 1 next cycle.
6. Case 4 with rst_n pulsed low mid-SHIFT -> outValid 0 and inReady 1 asynchronously, outputs 0; aIn=0x7F800000, bIn=0x3F800000 afterwards -> specialOut=1, fracSmall=0x00800000 unshifted, latency 1.
